// File: rtl/accel_pkg.sv
// Shared accelerator definitions: address geometry, entry widths and field
// layouts for the parameter stack and its per-entry execution state.
package accel_pkg;

  localparam int unsigned ADDR_W  = 12;
  localparam int unsigned DEPTH   = 4096;
  localparam int unsigned INEX_W  = 32;
  localparam int unsigned STATE_W = 18;
  localparam int unsigned POS_W   = 5;

  typedef struct packed {
    logic [7:0] i;
    logic [7:0] z;
    logic [7:0] k;
    logic [7:0] l;
  } inex_t;

  // State entry: position in the low bits, remaining execution flags above it.
  localparam int unsigned STATE_POS_LSB   = 0;
  localparam int unsigned STATE_POS_MSB   = POS_W - 1;
  localparam int unsigned STATE_FLAGS_LSB = POS_W;
  localparam int unsigned STATE_FLAGS_MSB = STATE_W - 1;

  typedef enum logic [1:0] {
    RD_NONE,
    RD_SEQ,
    RD_RAN
  } rd_sel_t;

  function automatic logic [INEX_W-1:0] pack_inex(input logic [7:0] i,
                                                  input logic [7:0] z,
                                                  input logic [7:0] k,
                                                  input logic [7:0] l);
    return {i, z, k, l};
  endfunction

endpackage

// File: rtl/param_regfile_mem.sv
// Entry array with two write ports (append and patch, never the same address)
// and one registered read port with read-before-write behaviour.
module param_regfile_mem #(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we_a,
  input  logic [ADDR_W-1:0] waddr_a,
  input  logic [DATA_W-1:0] wdata_a,
  input  logic              we_b,
  input  logic [ADDR_W-1:0] waddr_b,
  input  logic [DATA_W-1:0] wdata_b,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we_a) mem_q[waddr_a] <= wdata_a;
    if (we_b) mem_q[waddr_b] <= wdata_b;
  end

  // Output register holds its value between successful reads.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)     rdata_o <= '0;
    else if (re) rdata_o <= mem_q[raddr];
  end

endmodule

// File: rtl/param_regfile.sv
// Parameter-stack storage: append, cyclic sequential scan and in-place random
// access, with occupancy count and sticky error flag.
module param_regfile
  import accel_pkg::*;
#(
  parameter int unsigned ADDR_W = accel_pkg::ADDR_W,
  parameter int unsigned DEPTH  = accel_pkg::DEPTH,
  parameter int unsigned DATA_W = INEX_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              re_seq,
  input  logic              re_ran,
  input  logic [ADDR_W-1:0] r_addr,
  input  logic              seq_we,
  input  logic [DATA_W-1:0] seq_w_data,
  input  logic              ran_we,
  input  logic [ADDR_W-1:0] ran_w_addr,
  input  logic [DATA_W-1:0] ran_w_data,
  output logic [ADDR_W-1:0] addr_o,
  output logic [DATA_W-1:0] data_o,
  output logic              valid_o,
  output logic              wrap_o,
  output logic [ADDR_W:0]   count_o,
  output logic              empty_o,
  output logic              full_o,
  output logic              err_o
);

  localparam logic [ADDR_W:0] CNT_ONE = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0] CNT_MAX = (ADDR_W+1)'(DEPTH);

  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d, addr_q, addr_d;
  logic [ADDR_W:0]   count_q, count_d, ptr_inc;
  logic              err_q, err_d, valid_q, valid_d, wrap_q, wrap_d;
  logic              wrapped_q, wrapped_d;
  logic              full, empty, ran_rd_ok, ran_wr_ok;
  logic              mem_re, app_ok, patch_ok;
  logic [ADDR_W-1:0] mem_raddr;
  rd_sel_t           rd_sel;

  assign full      = (count_q == CNT_MAX);
  assign empty     = (count_q == '0);
  assign ran_rd_ok = ({1'b0, r_addr} < count_q);
  assign ran_wr_ok = ({1'b0, ran_w_addr} < count_q);
  assign ptr_inc   = {1'b0, rd_ptr_q} + CNT_ONE;

  always_comb begin
    rd_sel = RD_NONE;
    if (re_ran)                rd_sel = RD_RAN;
    else if (re_seq && !empty) rd_sel = RD_SEQ;

    mem_re    = !clr && ((rd_sel == RD_RAN && ran_rd_ok) || rd_sel == RD_SEQ);
    mem_raddr = (rd_sel == RD_RAN) ? r_addr : rd_ptr_q;
    app_ok    = !clr && seq_we && !full;
    patch_ok  = !clr && ran_we && ran_wr_ok;

    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    err_d     = err_q;
    addr_d    = addr_q;
    wrapped_d = wrapped_q;
    valid_d   = 1'b0;
    wrap_d    = 1'b0;

    if (clr) begin
      rd_ptr_d  = '0;
      count_d   = '0;
      err_d     = 1'b0;
      wrapped_d = 1'b0;
    end else begin
      case (rd_sel)
        RD_RAN: begin
          if (ran_rd_ok) begin
            valid_d = 1'b1;
            addr_d  = r_addr;
          end else begin
            err_d = 1'b1;
          end
        end
        RD_SEQ: begin
          valid_d = 1'b1;
          addr_d  = rd_ptr_q;
          // Once the pointer has wrapped, presenting entry 0 again marks a completed pass.
          wrap_d  = wrapped_q && (rd_ptr_q == '0);
          if (ptr_inc == count_q) begin
            rd_ptr_d  = '0;
            wrapped_d = 1'b1;
          end else begin
            rd_ptr_d = ptr_inc[ADDR_W-1:0];
          end
        end
        default: ;
      endcase
      if (ran_we && !ran_wr_ok) err_d = 1'b1;
      if (seq_we) begin
        if (full) err_d = 1'b1;
        else      count_d = count_q + CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q  <= '0;
      count_q   <= '0;
      err_q     <= 1'b0;
      addr_q    <= '0;
      valid_q   <= 1'b0;
      wrap_q    <= 1'b0;
      wrapped_q <= 1'b0;
    end else begin
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      err_q     <= err_d;
      addr_q    <= addr_d;
      valid_q   <= valid_d;
      wrap_q    <= wrap_d;
      wrapped_q <= wrapped_d;
    end
  end

  param_regfile_mem #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_mem (
    .clk     (clk),
    .rst     (rst),
    .we_a    (app_ok),
    .waddr_a (count_q[ADDR_W-1:0]),
    .wdata_a (seq_w_data),
    .we_b    (patch_ok),
    .waddr_b (ran_w_addr),
    .wdata_b (ran_w_data),
    .re      (mem_re),
    .raddr   (mem_raddr),
    .rdata_o (data_o)
  );

  assign addr_o  = addr_q;
  assign valid_o = valid_q;
  assign wrap_o  = wrap_q;
  assign count_o = count_q;
  assign empty_o = empty;
  assign full_o  = full;
  assign err_o   = err_q;

endmodule

// File: tb/tb_param_regfile.sv
// Scoreboard bench for param_regfile: directed scenarios plus random traffic,
// checked against an array-based behavioural model of the storage.
module tb_param_regfile;

  localparam int AW = 3;
  localparam int DP = 4;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst, clr, re_seq, re_ran, seq_we, ran_we;
  logic [AW-1:0] r_addr, ran_w_addr, addr_o;
  logic [DW-1:0] seq_w_data, ran_w_data, data_o;
  logic          valid_o, wrap_o, empty_o, full_o, err_o;
  logic [AW:0]   count_o;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit            v;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    bit            w;
    int            c;
    bit            e;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;

  // Reference model state
  logic [DW-1:0] m_mem[DP];
  int            m_cnt, m_ptr;
  bit            m_err, m_started;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;

  param_regfile #(.ADDR_W(AW), .DEPTH(DP), .DATA_W(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .clr        (clr),
    .re_seq     (re_seq),
    .re_ran     (re_ran),
    .r_addr     (r_addr),
    .seq_we     (seq_we),
    .seq_w_data (seq_w_data),
    .ran_we     (ran_we),
    .ran_w_addr (ran_w_addr),
    .ran_w_data (ran_w_data),
    .addr_o     (addr_o),
    .data_o     (data_o),
    .valid_o    (valid_o),
    .wrap_o     (wrap_o),
    .count_o    (count_o),
    .empty_o    (empty_o),
    .full_o     (full_o),
    .err_o      (err_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", n, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0; m_ptr = 0; m_err = 0; m_started = 0;
    m_addr = '0; m_data = '0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_addr"},  64'(addr_o),  64'(0));
    chk({tag, "_data"},  64'(data_o),  64'(0));
    chk({tag, "_valid"}, 64'(valid_o), 64'(0));
    chk({tag, "_wrap"},  64'(wrap_o),  64'(0));
    chk({tag, "_count"}, 64'(count_o), 64'(0));
    chk({tag, "_empty"}, 64'(empty_o), 64'(1));
    chk({tag, "_full"},  64'(full_o),  64'(0));
    chk({tag, "_err"},   64'(err_o),   64'(0));
  endtask

  // One request cycle: drive inputs, advance the model, queue the expected response.
  task automatic cyc(input bit rs, input bit rr, input int ra, input bit sw,
                     input logic [DW-1:0] sd, input bit rw, input int wa,
                     input logic [DW-1:0] wd, input bit cl);
    exp_t e;
    int   oc;
    @(negedge clk);
    re_seq = rs; re_ran = rr; r_addr = AW'(ra);
    seq_we = sw; seq_w_data = sd;
    ran_we = rw; ran_w_addr = AW'(wa); ran_w_data = wd;
    clr = cl;
    e.v = 0; e.w = 0;
    if (cl) begin
      m_cnt = 0; m_ptr = 0; m_err = 0; m_started = 0;
    end else begin
      if (rr) begin
        if (ra < m_cnt) begin
          e.v = 1; m_addr = AW'(ra); m_data = m_mem[ra];
        end else m_err = 1;
      end else if (rs && m_cnt > 0) begin
        e.v = 1; m_addr = AW'(m_ptr); m_data = m_mem[m_ptr];
        e.w = m_started && (m_ptr == 0);
        m_started = 1;
        m_ptr = (m_ptr + 1) % m_cnt;
      end
      oc = m_cnt;
      if (rw) begin
        if (wa < oc) m_mem[wa] = wd;
        else m_err = 1;
      end
      if (sw) begin
        if (oc == DP) m_err = 1;
        else begin
          m_mem[oc] = sd;
          m_cnt++;
        end
      end
    end
    e.a = m_addr; e.d = m_data; e.c = m_cnt; e.e = m_err;
    sbq.push_back(e);
  endtask

  task automatic idle();                    cyc(0, 0, 0, 0, '0, 0, 0, '0, 0); endtask
  task automatic app(input logic [DW-1:0] d); cyc(0, 0, 0, 1, d, 0, 0, '0, 0); endtask
  task automatic seq();                     cyc(1, 0, 0, 0, '0, 0, 0, '0, 0); endtask
  task automatic rrd(input int a);          cyc(0, 1, a, 0, '0, 0, 0, '0, 0); endtask
  task automatic rwr(input int a, input logic [DW-1:0] d); cyc(0, 0, 0, 0, '0, 1, a, d, 0); endtask
  task automatic clear();                   cyc(0, 0, 0, 0, '0, 0, 0, '0, 1); endtask

  always @(posedge clk) begin
    #1;
    if (sbq.size() > 0) begin
      mon_e = sbq.pop_front();
      chk("valid", 64'(valid_o), 64'(mon_e.v));
      chk("addr",  64'(addr_o),  64'(mon_e.a));
      chk("data",  64'(data_o),  64'(mon_e.d));
      chk("wrap",  64'(wrap_o),  64'(mon_e.w));
      chk("count", 64'(count_o), 64'(mon_e.c));
      chk("empty", 64'(empty_o), 64'(mon_e.c == 0));
      chk("full",  64'(full_o),  64'(mon_e.c == DP));
      chk("err",   64'(err_o),   64'(mon_e.e));
    end
  end

  initial begin
    rst = 1; clr = 0; re_seq = 0; re_ran = 0; seq_we = 0; ran_we = 0;
    r_addr = '0; ran_w_addr = '0; seq_w_data = '0; ran_w_data = '0;
    for (int i = 0; i < DP; i++) m_mem[i] = '0;
    model_reset();
    #12;
    chk_reset_outputs("reset");
    @(negedge clk); rst = 0;

    // Append three entries, then scan four times across the wrap.
    app(32'h01020304); app(32'h05060708); app(32'h090A0B0C);
    seq(); seq(); seq(); seq();
    // Patch and read back; out-of-range patch sets the sticky error.
    rwr(1, 32'hDEADBEEF); rrd(1); rwr(5, 32'h12345678);
    // Same-cycle read and write of one address returns the old data.
    cyc(0, 1, 2, 0, '0, 1, 2, 32'h11111111, 0);
    rrd(2);
    // Random read wins over sequential read; pointer stays put.
    cyc(1, 1, 0, 0, '0, 0, 0, '0, 0);
    seq();
    // Fill, overflow, clear.
    app(32'hA5A5A5A5); app(32'h5A5A5A5A);
    clear();
    seq();
    app(32'hCAFEF00D); app(32'h0BADBEEF); seq();
    idle();

    // Asynchronous reset mid-scan.
    @(posedge clk); #2;
    rst = 1;
    #1;
    chk_reset_outputs("midrst");
    model_reset();
    @(negedge clk); @(negedge clk); rst = 0;
    seq();
    app(32'h76543210); seq(); seq();

    // Random traffic.
    for (int n = 0; n < 600; n++) begin
      cyc($urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0, int'($urandom_range(0, 7)),
          $urandom_range(0, 2) == 0, $urandom, $urandom_range(0, 3) == 0,
          int'($urandom_range(0, 7)), $urandom, $urandom_range(0, 24) == 0);
    end
    idle();
    @(posedge clk); #3;
    chk("sb_drain", 64'(sbq.size()), 64'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
